// File: rtl/mips_pkg.sv
// Shared MIPS instruction-format constants.
// Field bit positions and the instruction width used by the IF/ID queue and decoders.
package mips_pkg;

    localparam int INSTR_W   = 32;

    localparam int OP_MSB    = 31;
    localparam int OP_LSB    = 26;
    localparam int RS_MSB    = 25;
    localparam int RS_LSB    = 21;
    localparam int RT_MSB    = 20;
    localparam int RT_LSB    = 16;
    localparam int RD_MSB    = 15;
    localparam int RD_LSB    = 11;
    localparam int SHAMT_MSB = 10;
    localparam int SHAMT_LSB = 6;
    localparam int FUNCT_MSB = 5;
    localparam int FUNCT_LSB = 0;
    localparam int IMM16_MSB = 15;
    localparam int IMM16_LSB = 0;
    localparam int IMM26_MSB = 25;
    localparam int IMM26_LSB = 0;

    localparam int IMM16_W   = IMM16_MSB - IMM16_LSB + 1;

endpackage

// File: rtl/instr_fields.sv
// Combinational field splitter with sign/zero extension of the 16-bit immediate.
// Ports: i_valid, i_instr in; o_opcode..o_imm26, o_imm_sext, o_imm_zext out (all 0 when !i_valid).
module instr_fields
    import mips_pkg::*;
(
    input  logic               i_valid,
    input  logic [INSTR_W-1:0] i_instr,
    output logic [5:0]         o_opcode,
    output logic [4:0]         o_rs,
    output logic [4:0]         o_rt,
    output logic [4:0]         o_rd,
    output logic [4:0]         o_shamt,
    output logic [5:0]         o_funct,
    output logic [15:0]        o_imm16,
    output logic [25:0]        o_imm26,
    output logic [31:0]        o_imm_sext,
    output logic [31:0]        o_imm_zext
);

    logic [INSTR_W-1:0] w_word;

    // Gating the word once zeroes every derived field when invalid.
    assign w_word     = i_valid ? i_instr : '0;

    assign o_opcode   = w_word[OP_MSB:OP_LSB];
    assign o_rs       = w_word[RS_MSB:RS_LSB];
    assign o_rt       = w_word[RT_MSB:RT_LSB];
    assign o_rd       = w_word[RD_MSB:RD_LSB];
    assign o_shamt    = w_word[SHAMT_MSB:SHAMT_LSB];
    assign o_funct    = w_word[FUNCT_MSB:FUNCT_LSB];
    assign o_imm16    = w_word[IMM16_MSB:IMM16_LSB];
    assign o_imm26    = w_word[IMM26_MSB:IMM26_LSB];
    assign o_imm_sext = {{(32-IMM16_W){w_word[IMM16_MSB]}},
                         w_word[IMM16_MSB:IMM16_LSB]};
    assign o_imm_zext = {{(32-IMM16_W){1'b0}},
                         w_word[IMM16_MSB:IMM16_LSB]};

endmodule

// File: rtl/instr_field_queue.sv
// IF->ID instruction queue: DEPTH-entry FIFO of {instr, pc} with pre-split head fields.
// Ports: clk, reset (async low), flush; in_* push side; out_*/fields/count head side.
module instr_field_queue
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [INSTR_W-1:0]         in_instr,
    input  logic [PC_W-1:0]            in_pc,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [INSTR_W-1:0]         out_instr,
    output logic [PC_W-1:0]            out_pc,
    output logic [5:0]                 opcode,
    output logic [4:0]                 rs,
    output logic [4:0]                 rt,
    output logic [4:0]                 rd,
    output logic [4:0]                 shamt,
    output logic [5:0]                 funct,
    output logic [15:0]                imm16,
    output logic [25:0]                imm26,
    output logic [31:0]                imm_sext,
    output logic [31:0]                imm_zext,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [INSTR_W-1:0] r_instr_mem [DEPTH];
    logic [PC_W-1:0]    r_pc_mem    [DEPTH];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic w_full;
    logic w_valid;
    logic w_push;
    logic w_pop;

    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_valid   = (r_count != '0);
    // Full blocks pushes even when a pop frees a slot this cycle.
    assign in_ready  = reset & ~w_full;
    assign out_valid = w_valid;
    assign count     = r_count;

    assign w_push = in_valid & in_ready & ~flush;
    assign w_pop  = w_valid & out_ready & ~flush;

    // Power-of-two DEPTH lets the pointers wrap naturally.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;
        end
    end

    // Storage holds no reset; validity comes from r_count alone.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_instr_mem[r_wr_ptr] <= in_instr;
            r_pc_mem[r_wr_ptr]    <= in_pc;
        end
    end

    assign out_instr = w_valid ? r_instr_mem[r_rd_ptr] : '0;
    assign out_pc    = w_valid ? r_pc_mem[r_rd_ptr]    : '0;

    instr_fields u_fields (
        .i_valid    (w_valid),
        .i_instr    (r_instr_mem[r_rd_ptr]),
        .o_opcode   (opcode),
        .o_rs       (rs),
        .o_rt       (rt),
        .o_rd       (rd),
        .o_shamt    (shamt),
        .o_funct    (funct),
        .o_imm16    (imm16),
        .o_imm26    (imm26),
        .o_imm_sext (imm_sext),
        .o_imm_zext (imm_zext)
    );

endmodule

// File: tb/tb_instr_field_queue.sv
// Self-checking bench for instr_field_queue: vector table, corner sequences, random vs queue model.
// Drives after each rising edge (+1) and checks the settled outputs there.
module tb_instr_field_queue;

    localparam int DEPTH = 4;
    localparam int PC_W  = 32;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic [31:0] in_pc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [5:0]  opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] imm26;
    logic [31:0] imm_sext, imm_zext;
    logic [2:0]  count;

    always #5 clk = ~clk;

    instr_field_queue #(.DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr), .out_pc(out_pc),
        .opcode(opcode), .rs(rs), .rt(rt), .rd(rd),
        .shamt(shamt), .funct(funct), .imm16(imm16),
        .imm26(imm26), .imm_sext(imm_sext),
        .imm_zext(imm_zext), .count(count)
    );

    typedef struct {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    ent_t q[$];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h t=%0t", nm, got, exp, $time);
        end
    endtask

    // Expected outputs derived from the model head with plain arithmetic.
    task automatic check_all(input string tag);
        int unsigned h, p, i16;
        bit v;
        v = (q.size() != 0);
        h = v ? q[0].ins : 0;
        p = v ? q[0].pc : 0;
        i16 = h % 65536;
        chk({tag, ".out_valid"}, {31'b0, out_valid}, {31'b0, v});
        chk({tag, ".in_ready"}, {31'b0, in_ready},
            (q.size() < DEPTH) ? 32'd1 : 32'd0);
        chk({tag, ".count"}, {29'b0, count}, q.size());
        chk({tag, ".out_instr"}, out_instr, h);
        chk({tag, ".out_pc"}, out_pc, p);
        chk({tag, ".opcode"}, {26'b0, opcode}, h / (1 << 26));
        chk({tag, ".rs"}, {27'b0, rs}, (h / (1 << 21)) % 32);
        chk({tag, ".rt"}, {27'b0, rt}, (h / (1 << 16)) % 32);
        chk({tag, ".rd"}, {27'b0, rd}, (h / (1 << 11)) % 32);
        chk({tag, ".shamt"}, {27'b0, shamt}, (h / 64) % 32);
        chk({tag, ".funct"}, {26'b0, funct}, h % 64);
        chk({tag, ".imm16"}, {16'b0, imm16}, i16);
        chk({tag, ".imm26"}, {6'b0, imm26}, h % (1 << 26));
        chk({tag, ".imm_zext"}, imm_zext, i16);
        chk({tag, ".imm_sext"}, imm_sext,
            (i16 >= 32768) ? i16 + 32'hFFFF0000 : i16);
    endtask

    // One clock: drive, predict from model, advance, check.
    task automatic step(input logic iv, input logic ordy, input logic fl,
                        input logic [31:0] ins, input logic [31:0] pc,
                        input string tag);
        bit do_push, do_pop;
        ent_t e;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_instr  = ins;
        in_pc     = pc;
        do_push = iv && (q.size() < DEPTH) && !fl;
        do_pop  = ordy && (q.size() != 0) && !fl;
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else begin
            if (do_pop) void'(q.pop_front());
            if (do_push) begin
                e.ins = ins;
                e.pc  = pc;
                q.push_back(e);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        flush     = 1'b0;
        check_all(tag);
    endtask

    typedef struct {
        logic        iv;
        logic        ordy;
        logic [31:0] ins;
        logic [31:0] pc;
        logic        e_ov;
        int          e_cnt;
        logic [5:0]  e_op;
        logic [4:0]  e_rs, e_rt, e_rd, e_sh;
        logic [5:0]  e_fn;
        logic [15:0] e_i16;
        logic [31:0] e_sx, e_zx;
    } vec_t;

    vec_t vt[4];

    initial begin
        int unsigned pcv;
        logic [31:0] w;

        vt[0] = '{1, 0, 32'h8C8A0004, 32'h3000, 1, 1, 6'h23, 5'd4, 5'd10,
                  5'd0, 5'd0, 6'h04, 16'h0004, 32'h4, 32'h4};
        vt[1] = '{1, 1, 32'h2402FFFF, 32'h3004, 1, 1, 6'h09, 5'd0, 5'd2,
                  5'h1F, 5'h1F, 6'h3F, 16'hFFFF, 32'hFFFFFFFF, 32'h0000FFFF};
        vt[2] = '{1, 1, 32'h00031080, 32'h3008, 1, 1, 6'h00, 5'd0, 5'd3,
                  5'd2, 5'd2, 6'h00, 16'h1080, 32'h1080, 32'h1080};
        vt[3] = '{0, 1, 32'h0, 32'h0, 0, 0, 6'h0, 5'd0, 5'd0,
                  5'd0, 5'd0, 6'h0, 16'h0, 32'h0, 32'h0};

        // Reset held low across edges.
        repeat (2) @(posedge clk);
        #1;
        chk("rst.in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst.out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst.count", {29'b0, count}, 32'd0);
        reset = 1'b1;
        #1;
        check_all("rel");

        // Vector table: literal expected fields.
        for (int i = 0; i < 4; i++) begin
            step(vt[i].iv, vt[i].ordy, 1'b0, vt[i].ins, vt[i].pc,
                 $sformatf("vec%0d", i));
            chk($sformatf("vec%0d.ov", i), {31'b0, out_valid},
                {31'b0, vt[i].e_ov});
            chk($sformatf("vec%0d.cnt", i), {29'b0, count}, vt[i].e_cnt);
            chk($sformatf("vec%0d.op", i), {26'b0, opcode}, {26'b0, vt[i].e_op});
            chk($sformatf("vec%0d.rs", i), {27'b0, rs}, {27'b0, vt[i].e_rs});
            chk($sformatf("vec%0d.rt", i), {27'b0, rt}, {27'b0, vt[i].e_rt});
            chk($sformatf("vec%0d.rd", i), {27'b0, rd}, {27'b0, vt[i].e_rd});
            chk($sformatf("vec%0d.sh", i), {27'b0, shamt}, {27'b0, vt[i].e_sh});
            chk($sformatf("vec%0d.fn", i), {26'b0, funct}, {26'b0, vt[i].e_fn});
            chk($sformatf("vec%0d.i16", i), {16'b0, imm16}, {16'b0, vt[i].e_i16});
            chk($sformatf("vec%0d.sx", i), imm_sext, vt[i].e_sx);
            chk($sformatf("vec%0d.zx", i), imm_zext, vt[i].e_zx);
        end

        // Fill to full, 5th push refused, pop-while-full takes no write-through.
        for (int i = 0; i < 4; i++)
            step(1, 0, 0, 32'h1000_0000 + i, 32'h4000 + 4 * i, "fill");
        chk("full.count", {29'b0, count}, 32'd4);
        chk("full.in_ready", {31'b0, in_ready}, 32'd0);
        step(1, 0, 0, 32'hDEAD_BEEF, 32'h4010, "fifth");
        chk("fifth.count", {29'b0, count}, 32'd4);
        step(1, 1, 0, 32'hBAD0_0001, 32'h4014, "popfull");
        chk("popfull.in_ready", {31'b0, in_ready}, 32'd1);
        chk("popfull.count", {29'b0, count}, 32'd3);
        chk("popfull.head", out_instr, 32'h1000_0001);

        // Streaming 10 words at constant occupancy, wrapping the pointers.
        for (int i = 0; i < 10; i++) begin
            step(1, 1, 0, 32'h2000_0000 + i, 32'h5000 + 4 * i, "stream");
            chk("stream.count", {29'b0, count}, 32'd3);
        end

        // Flush with 3 entries plus simultaneous push and pop.
        step(1, 1, 1, 32'hF1F1_F1F1, 32'h6000, "flush");
        chk("flush.count", {29'b0, count}, 32'd0);
        chk("flush.ov", {31'b0, out_valid}, 32'd0);
        chk("flush.ir", {31'b0, in_ready}, 32'd1);
        chk("flush.sext", imm_sext, 32'd0);
        step(1, 0, 0, 32'h3C01_1234, 32'h6004, "postflush");
        chk("postflush.head", out_instr, 32'h3C01_1234);
        chk("postflush.count", {29'b0, count}, 32'd1);

        // Asynchronous reset between edges mid-burst.
        step(1, 0, 0, 32'h1111_2222, 32'h7000, "burst");
        step(1, 0, 0, 32'h3333_4444, 32'h7004, "burst");
        #2;
        reset = 1'b0;
        #1;
        chk("arst.ov", {31'b0, out_valid}, 32'd0);
        chk("arst.count", {29'b0, count}, 32'd0);
        chk("arst.ir", {31'b0, in_ready}, 32'd0);
        chk("arst.op", {26'b0, opcode}, 32'd0);
        q.delete();
        @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check_all("arst.rel");
        step(1, 0, 0, 32'h8C8A0004, 32'h3000, "arst.push");
        chk("arst.push.op", {26'b0, opcode}, 32'h23);

        // Randomised traffic against the queue model.
        pcv = 32'h8000;
        for (int i = 0; i < 400; i++) begin
            w = $urandom;
            step($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                 $urandom_range(0, 99) < 4, w, pcv, "rand");
            pcv += 4;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_field_queue.md
# instr_field_queue

Parametrised instruction buffer between fetch (IF) and decode (ID) of the pipelined MIPS core. It stores up to DEPTH fetched instructions with their PCs under a valid/ready handshake. The head entry is presented already split into opcode, rs, rt, rd, shamt, funct, imm16 and imm26, plus sign- and zero-extended 32-bit immediates, so ID no longer carries its own field splitter. It supports flush on branch/jump redirect and gives decode a stall-tolerant, decoupled input.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- PC_W, 32, PC width
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low; queue cleared while low
- flush  in  1  synchronous discard of all entries (redirect)
- in_valid  in  1  fetch presents an instruction
- in_ready  out  1  queue can accept this cycle
- in_instr  in  32  fetched instruction word
- in_pc  in  PC_W  PC of in_instr
- out_valid  out  1  head entry valid
- out_ready  in  1  decode consumes head this cycle
- out_instr  out  32  head instruction
- out_pc  out  PC_W  head PC
- opcode  out  6  head[31:26]
- rs  out  5  head[25:21]
- rt  out  5  head[20:16]
- rd  out  5  head[15:11]
- shamt  out  5  head[10:6]
- funct  out  6  head[5:0]
- imm16  out  16  head[15:0]
- imm26  out  26  head[25:0]
- imm_sext  out  32  {{16{head[15]}}, head[15:0]}
- imm_zext  out  32  {16'b0, head[15:0]}
- count  out  $clog2(DEPTH+1)  occupied entries

## Operation
- Circular buffer: wr_ptr, rd_ptr ($clog2(DEPTH) bits, wrap modulo DEPTH) and count register.
- push = in_valid & in_ready & ~flush; pop = out_valid & out_ready & ~flush.
- in_ready = reset & (count < DEPTH); no write-through when full, even if a pop occurs the same cycle.
- out_valid = (count != 0).
- push only: write entry at wr_ptr, wr_ptr+1, count+1. Pop only: rd_ptr+1, count−1. Push and pop together: both pointers advance, count unchanged.
- flush: next edge sets wr_ptr = rd_ptr = 0 and count = 0. It overrides any simultaneous push or pop; the input word on that cycle is dropped and the head is not consumed.
- All field and extended outputs are combinational from the head entry, gated to zero when out_valid = 0. out_instr and out_pc are also zero when empty.
- Storage array is not reset; only pointers and count are.
- Reset (any time, including mid-burst): pointers and count go to 0 immediately. out_valid = 0, all field outputs = 0, count = 0, in_ready = 0 while reset is low and 1 from the first cycle after release.

## Timing
- Push-to-head latency: an instruction pushed at edge N into an empty queue is visible with out_valid = 1 after edge N, in the same cycle decode can pop it. There is no combinational in→out bypass.
- Pop takes effect at the clock edge. The next entry, or empty, is visible after that edge.
- Full to non-full: in_ready rises the cycle after a pop from a full queue.
- flush asserted in cycle N: out_valid = 0 and in_ready = 1 in cycle N+1.
- Ordering is strictly FIFO across pointer wrap.

## Structure
- Shared package mips_pkg: field-position constants (OP_MSB/LSB, RS_MSB/LSB, RT, RD, SHAMT, FUNCT, IMM16, IMM26) and the instruction width constant INSTR_W = 32. The queue and any decoder use these constants.
- One natural sub-module, instr_fields: purely combinational split plus extension of a 32-bit word with a valid gate. It is instantiated once on the head entry.

## Test plan
- Reset then single push of 0x8C8A0004 at PC 0x3000 → next cycle out_valid = 1, opcode = 0x23, rs = 4, rt = 10, imm16 = 0x0004, imm_sext = 0x00000004, count = 1.
- Push 0x2402FFFF → imm_sext = 0xFFFFFFFF, imm_zext = 0x0000FFFF. Push 0x00031080 → rd = 2, shamt = 2, funct = 0x00.
- With out_ready = 0, push 4 words (DEPTH = 4) → count = 4, in_ready = 0. The 5th in_valid is not accepted. Pop 1 → in_ready = 1 the next cycle.
- Continuous push and pop for 10 words → count stays constant, output order equals input order across two pointer wraps, PCs match.
- Queue holding 3 entries, flush asserted together with in_valid and out_ready → next cycle count = 0, out_valid = 0, all fields 0, and the flush-cycle input is absent afterwards.
- reset driven low mid-burst asynchronously, between clock edges → out_valid and count go to 0 without waiting for an edge. After release, first push appears normally.
